// File: rtl/trace_pkg.sv
// Shared types and constants for the data-memory write tracer:
// TX FSM states, record length and UART framing levels.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int   REC_BYTES = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Record bytes go out most significant first: addr hi, addr lo, data hi, data lo.
  function automatic logic [7:0] rec_byte(input logic [31:0] rec, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = rec[31:24];
      2'd1:    b = rec[23:16];
      2'd2:    b = rec[15:8];
      2'd3:    b = rec[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous circular FIFO; a push into a full FIFO is taken only when a
// pop happens on the same edge.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against occupancy.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage; the read port samples before this edge's write lands.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/wr_trace_uart.sv
// Captures every RAM write as {addr, data} and streams each one out as a
// 4-byte 8N1 UART record.
module wr_trace_uart
  import trace_pkg::*;
#(
  parameter int BITS         = 16,
  parameter int DTBITS       = 11,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_Wr,
  input  logic [DTBITS-1:0] i_Addr,
  input  logic [BITS-1:0]   i_Data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  logic [31:0]   push_word_s;
  logic [31:0]   pop_word_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW:0]   fifo_count_s;
  logic          pop_s;
  logic          baud_done_s;
  logic [7:0]    cur_byte_s;

  tx_state_e     state_r;
  logic [BW-1:0] baud_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [1:0]    byte_idx_r;
  logic [31:0]   rec_r;
  logic          tx_r;
  logic          busy_r;
  logic          ovf_r;

  assign push_word_s = {16'(i_Addr), i_Data};

  trace_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (i_clock),
    .reset (i_reset),
    .push  (i_Wr),
    .pop   (pop_s),
    .din   (push_word_s),
    .dout  (pop_word_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Pop when idle, or at the end of a record's last stop bit so records chain with no gap.
  always_comb begin
    baud_done_s = (baud_cnt_r == BW'(CLKS_PER_BIT - 1));
    cur_byte_s  = rec_byte(rec_r, byte_idx_r);
    pop_s       = 1'b0;
    if (!fifo_empty_s) begin
      case (state_r)
        IDLE:    pop_s = 1'b1;
        STOP:    pop_s = baud_done_s & (byte_idx_r == 2'(REC_BYTES - 1));
        default: pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // TX FSM with baud timing, plus the registered status flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 2'd0;
      rec_r      <= 32'h0;
      tx_r       <= STOP_BIT;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      busy_r <= (state_r != IDLE) | (fifo_count_s != '0);
      ovf_r  <= ovf_r | (i_Wr & fifo_full_s & ~pop_s);
      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          tx_r       <= STOP_BIT;
          if (pop_s) begin
            rec_r      <= pop_word_s;
            byte_idx_r <= 2'd0;
            tx_r       <= START_BIT;
            state_r    <= START;
          end
        end
        START: begin
          if (baud_done_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            tx_r       <= cur_byte_s[0];
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        DATA: begin
          if (baud_done_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              tx_r    <= STOP_BIT;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= cur_byte_s[bit_idx_r + 3'd1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        STOP: begin
          if (baud_done_s) begin
            baud_cnt_r <= '0;
            if (byte_idx_r != 2'(REC_BYTES - 1)) begin
              byte_idx_r <= byte_idx_r + 2'd1;
              tx_r       <= START_BIT;
              state_r    <= START;
            end else if (pop_s) begin
              rec_r      <= pop_word_s;
              byte_idx_r <= 2'd0;
              tx_r       <= START_BIT;
              state_r    <= START;
            end else begin
              tx_r    <= STOP_BIT;
              state_r <= IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        default: begin
          tx_r    <= STOP_BIT;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_tx       = tx_r;
  assign o_busy     = busy_r;
  assign o_overflow = ovf_r;

endmodule

// File: tb/tb_wr_trace_uart.sv
// Directed + randomized bench for wr_trace_uart: a UART line monitor decodes
// frames, and an occupancy/sender-time model predicts records, busy and overflow.
module tb_wr_trace_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int REC   = 40 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [10:0] addr = 11'h0;
  logic [15:0] data = 16'h0;
  logic        tx, busy, ovf;

  wr_trace_uart #(.BITS(16), .DTBITS(11), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .i_clock(clk), .i_reset(rst), .i_Wr(wr), .i_Addr(addr), .i_Data(data),
    .o_tx(tx), .o_busy(busy), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int edge_n; logic [7:0] b; logic stop; } byte_t;
  typedef struct { int edge_n; logic [15:0] a; logic [15:0] d; } rec_t;

  byte_t mon_q[$];
  rec_t  pend_q[$];
  rec_t  sent_q[$];

  int checks = 0;
  int errors = 0;
  int occ = 0;
  int free_edge = 0;
  int e_cur = 0;
  bit act = 1'b0;
  bit ovf_m = 1'b0;
  bit busy_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check flags after it.
  task automatic step(input bit w, input logic [10:0] a, input logic [15:0] d, input bit r);
    rec_t rc;
    bit   pop, accept, new_act, busy_nxt;
    rst = r; wr = w; addr = a; data = d;
    @(posedge clk);
    e_cur = int'(($time - 5) / 10);
    if (r) begin
      occ = 0; pend_q.delete(); act = 1'b0; ovf_m = 1'b0; busy_m = 1'b0;
    end else begin
      busy_nxt = act || (occ > 0);
      pop      = (occ > 0) && (!act || e_cur == free_edge);
      new_act  = pop || (act && e_cur < free_edge);
      accept   = w && (occ < DEPTH || pop);
      if (pop) begin
        rc = pend_q.pop_front();
        rc.edge_n = e_cur;
        sent_q.push_back(rc);
        occ--;
        free_edge = e_cur + REC;
      end
      if (accept) begin
        rc.edge_n = 0; rc.a = {5'b0, a}; rc.d = d;
        pend_q.push_back(rc);
        occ++;
      end else if (w) begin
        ovf_m = 1'b1;
      end
      act = new_act;
      busy_m = busy_nxt;
    end
    @(negedge clk);
    chk("overflow", {31'b0, ovf}, {31'b0, ovf_m});
    chk("busy", {31'b0, busy}, {31'b0, busy_m});
  endtask

  task automatic idle(input int n, input bit check_tx);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 11'h0, 16'h0, 1'b0);
      if (check_tx) chk("tx_idle", {31'b0, tx}, 32'd1);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((occ > 0 || act) && guard < 2000) begin
      step(1'b0, 11'h0, 16'h0, 1'b0);
      guard++;
    end
    chk("drain_timeout", (guard < 2000) ? 32'd1 : 32'd0, 32'd1);
    idle(CPB + 2, 1'b1);
  endtask

  // Compare the first nrec sent records against decoded bytes, then forget both.
  task automatic compare(input string tag, input int nrec);
    logic [31:0] w;
    chk({tag, "_nbytes"}, mon_q.size(), nrec * 4);
    for (int i = 0; i < nrec; i++) begin
      w = {sent_q[i].a, sent_q[i].d};
      for (int j = 0; j < 4; j++) begin
        if (i * 4 + j < mon_q.size()) begin
          chk({tag, "_byte"}, {24'b0, mon_q[i*4+j].b}, {24'b0, w[31-8*j -: 8]});
          chk({tag, "_edge"}, mon_q[i*4+j].edge_n, sent_q[i].edge_n + j * 10 * CPB);
          chk({tag, "_stop"}, {31'b0, mon_q[i*4+j].stop}, 32'd1);
        end
      end
    end
    mon_q.delete();
    sent_q.delete();
  endtask

  // UART line monitor: frame timing is exact, sample one cycle into each bit.
  initial begin
    byte_t    m;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        m.edge_n = int'(($time - 10) / 10);
        repeat (CPB + 1) @(negedge clk);
        m.b[0] = tx;
        for (int i = 1; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          m.b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        m.stop = tx;
        repeat (CPB - 2) @(negedge clk);
        mon_q.push_back(m);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_w;
    int guard;
    // Reset and quiet line.
    step(1'b0, 11'h0, 16'h0, 1'b1);
    step(1'b0, 11'h0, 16'h0, 1'b1);
    chk("reset_tx", {31'b0, tx}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_ovf", {31'b0, ovf}, 32'd0);
    idle(100, 1'b1);

    // Single write.
    step(1'b1, 11'h123, 16'hBEEF, 1'b0);
    e_w = e_cur;
    drain();
    chk("single_latency", mon_q[0].edge_n, e_w + 1);
    chk("single_b0", {24'b0, mon_q[0].b}, 32'h01);
    chk("single_b3", {24'b0, mon_q[3].b}, 32'hEF);
    compare("single", sent_q.size());

    // Three consecutive writes.
    for (int i = 1; i <= 3; i++) step(1'b1, 11'(i), 16'hA000 + 16'(i), 1'b0);
    drain();
    chk("three_gap", mon_q[4].edge_n, mon_q[0].edge_n + REC);
    compare("three", sent_q.size());

    // Six consecutive writes: one dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 11'($urandom), 16'($urandom), 1'b0);
    drain();
    chk("six_records", mon_q.size(), 20);
    chk("six_ovf", {31'b0, ovf}, 32'd1);
    compare("six", sent_q.size());
    idle(20, 1'b1);

    step(1'b0, 11'h0, 16'h0, 1'b1);
    chk("ovf_cleared", {31'b0, ovf}, 32'd0);

    // Push on the pop edge while full.
    for (int i = 0; i < 5; i++) step(1'b1, 11'($urandom), 16'($urandom), 1'b0);
    chk("full_occ", occ, DEPTH);
    guard = 0;
    while (e_cur + 1 != free_edge && guard < 500) begin
      step(1'b0, 11'h0, 16'h0, 1'b0);
      guard++;
    end
    step(1'b1, 11'h7FF, 16'h5A5A, 1'b0);
    drain();
    chk("fullpop_records", mon_q.size(), 24);
    chk("fullpop_ovf", {31'b0, ovf}, 32'd0);
    compare("fullpop", sent_q.size());

    // Reset mid-byte of the second record.
    step(1'b1, 11'($urandom), 16'($urandom), 1'b0);
    step(1'b1, 11'($urandom), 16'($urandom), 1'b0);
    guard = 0;
    while (sent_q.size() < 2 && guard < 500) begin
      step(1'b0, 11'h0, 16'h0, 1'b0);
      guard++;
    end
    idle(15, 1'b0);
    compare("prereset", 1);
    step(1'b0, 11'h0, 16'h0, 1'b1);
    chk("midreset_tx", {31'b0, tx}, 32'd1);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    idle(50, 1'b1);
    mon_q.delete();
    sent_q.delete();
    step(1'b1, 11'h456, 16'h1234, 1'b0);
    drain();
    compare("postreset", sent_q.size());

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) step(1'b1, 11'($urandom), 16'($urandom), 1'b0);
      else step(1'b0, 11'h0, 16'h0, 1'b0);
    end
    drain();
    compare("random", sent_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
